alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage of the RV32 integer pipeline: takes decoded operands/opcode from issue via valid/ready,
//  computes the ALU result (add/sub via the existing Adder_32), and holds it in an output register for
//  writeback via valid/ready. Registered output, full throughput; optional multi-cycle multiplier.
// PARAMETERS
//  XLEN   32  datapath width; fixed at 32 (Adder_32 width), other values unsupported
//  RD_W   5   destination register index width
// PORTS
//  clk           in   1     single clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  in_valid      in   1     issue offers an operation
//  in_ready      out  1     stage accepts; transfer when in_valid && in_ready
//  in_op         in   4     opcode (alu_pkg encoding)
//  in_a          in   32    operand A (rs1)
//  in_b          in   32    operand B (rs2/imm); shifts use in_b[4:0]
//  in_rd         in   5     destination register, passed through
//  out_valid     out  1     result held for writeback
//  out_ready     in   1     writeback consumes; transfer when out_valid && out_ready
//  out_result    out  32    result
//  out_rd        out  5     destination register of out_result
//  out_overflow  out  1     signed overflow (ADD/SUB only, else 0)
//  busy          out  1     multi-cycle op in flight
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_result=0, out_rd=0, out_overflow=0, busy=0, FSM=IDLE, count=0;
//    in_ready=0 while rst high. Reset mid-MUL aborts it; no output produced.
//  - Ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10; 11-15 illegal:
//    result 0, overflow 0, latency 1 (never hang).
//  - ADD/SUB: Adder_32 with sub=(op==SUB); out_overflow = Adder_32 overflow.
//  - SLT: Adder_32 in subtract mode; result = {31'b0, s[31]^overflow}.
//  - SLTU: result = (a[31]!=b[31]) ? b[31] : s[31] from the subtract; zero-extended.
//  - Shifts: amount in_b[4:0]; SRA sign-fills from a[31].
//  - Single-cycle ops: accepted at edge N -> out_valid=1 with result after edge N (latency 1).
//  - in_ready = !rst && state==IDLE && (!out_valid || out_ready). Simultaneous drain+accept in one
//    cycle gives 1 op/cycle throughput.
//  - Backpressure: while out_valid && !out_ready, out_result/out_rd/out_overflow held stable, in_ready=0.
//  - out_valid clears on drain with no new completion that cycle.
//  - FSM (MUL only): IDLE -> RUN on MUL accept (latch a, b, rd; count=0; busy=1).
//    RUN: shift-add one multiplier bit/cycle; after 32 iterations -> DONE.
//    DONE: when !out_valid || out_ready, load low 32 bits of product, overflow=0, out_valid=1, -> IDLE.
//    Unstalled MUL: out_valid rises 33 edges after acceptance. in_ready=0 in RUN/DONE; a pending prior
//    result may still drain during RUN.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL (op 10) via multi-cycle FSM as above, busy driven.
//  ALU_MUL_EN undefined: no FSM/multiplier; op 10 is illegal (result 0, latency 1); busy tied 0.
// STRUCTURE
//  - alu_pkg: opcode localparams (ALU_ADD..ALU_MUL), OP_W=4, XLEN=32, FSM state encodings
//    (ST_IDLE, ST_RUN, ST_DONE).
//  - Instantiates Adder_32 for ADD/SUB/SLT/SLTU.
//  - Sub-module alu_mul_seq (under ALU_MUL_EN): 32-cycle shift-add core with start/done; the stage
//    owns the handshake and DONE wait.
// TESTING
//  1. ADD a=0x7FFFFFFF b=1 -> next cycle out_valid=1, result=0x80000000, overflow=1; ADD 2+3 -> 5, ovf 0.
//  2. SUB 0x80000000-1 -> 0x7FFFFFFF, ovf 1; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
//  3. SRA a=0x80000000 b=0x21 -> 0xC0000000; SLL a=1 b=31 -> 0x80000000; op 13 -> result 0, latency 1.
//  4. out_ready=0 for 3 cycles, in_valid held -> in_ready=0, outputs stable;
//     then 4 back-to-back ADDs with out_ready=1 -> 4 results in 4 consecutive cycles, in order, correct rd.
//  5. ALU_MUL_EN: MUL 0x00010001*0x00010001 -> 0x00020001 after 33 edges, busy=1 and in_ready=0 meanwhile;
//     without macro -> result 0 next cycle.
//  6. rst pulsed at RUN cycle 10 -> out_valid=0, busy=0 immediately; after release ADD 2+3 -> 5 in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 execute stage: opcodes, widths, FSM states.
// Multi-cycle multiplier support is enabled by defining ALU_MUL_EN.
package alu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OP_W = 4;
   localparam int unsigned RD_W = 5;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;
   localparam logic [OP_W-1:0] ALU_MUL  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/Adder_32.sv
// 32-bit add/subtract with signed-overflow flag, shared by ADD/SUB/SLT/SLTU.
module Adder_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] s,
   output logic        overflow
);

   logic [31:0] b_eff;

   assign b_eff    = sub ? ~b : b;
   assign s        = a + b_eff + {31'b0, sub};
   assign overflow = (a[31] == b_eff[31]) && (s[31] != a[31]);

endmodule

// File: rtl/alu_mul_seq.sv
// 32-iteration shift-add multiplier core; done marks the edge of the final iteration.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic [4:0]      count;
   logic            running;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         mcand   <= a;
         mplier  <= b;
         acc     <= '0;
         count   <= '0;
         running <= 1'b1;
      end else if (running) begin
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 5'd1;
         if (count == 5'd31)
            running <= 1'b0;
      end
   end

   // Product is valid in acc right after the edge on which done is high.
   assign done    = running && (count == 5'd31);
   assign product = acc;

endmodule

// File: rtl/alu_exec_stage.sv
// RV32 execute stage: valid/ready in, registered result out, optional
// multi-cycle MUL when ALU_MUL_EN is defined.
module alu_exec_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [RD_W-1:0] out_rd,
   output logic            out_overflow,
   output logic            busy
);

   import alu_pkg::*;

   logic [XLEN-1:0] add_s;
   logic            add_ovf;
   logic            add_sub;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_result;
   logic            alu_ovf;
   logic            accept;

   // Everything except ADD runs the adder in subtract mode (SUB, SLT, SLTU).
   assign add_sub = (in_op != ALU_ADD);
   assign shamt   = in_b[4:0];

   Adder_32 u_adder (
      .a        (in_a),
      .b        (in_b),
      .sub      (add_sub),
      .s        (add_s),
      .overflow (add_ovf)
   );

   always_comb begin
      alu_result = '0;
      alu_ovf    = 1'b0;
      case (in_op)
         ALU_ADD,
         ALU_SUB:  begin
            alu_result = add_s;
            alu_ovf    = add_ovf;
         end
         ALU_AND:  alu_result = in_a & in_b;
         ALU_OR:   alu_result = in_a | in_b;
         ALU_XOR:  alu_result = in_a ^ in_b;
         ALU_SLL:  alu_result = in_a << shamt;
         ALU_SRL:  alu_result = in_a >> shamt;
         ALU_SRA:  alu_result = $signed(in_a) >>> shamt;
         ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, add_s[XLEN-1] ^ add_ovf};
         ALU_SLTU: alu_result = {{(XLEN-1){1'b0}},
                                 (in_a[XLEN-1] != in_b[XLEN-1]) ? in_b[XLEN-1] : add_s[XLEN-1]};
         default:  begin
            alu_result = '0;
            alu_ovf    = 1'b0;
         end
      endcase
   end

   assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
   alu_state_t      state;
   logic [RD_W-1:0] mul_rd;
   logic            mul_start;
   logic            mul_done;
   logic [XLEN-1:0] mul_product;

   assign mul_start = accept && (in_op == ALU_MUL);
   assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);

   alu_mul_seq u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (in_a),
      .b       (in_b),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         mul_rd       <= '0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd       <= '0;
         out_overflow <= 1'b0;
      end else begin
         // A drain may be overridden below by a completion in the same cycle.
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (in_op == ALU_MUL) begin
                     state  <= ST_RUN;
                     busy   <= 1'b1;
                     mul_rd <= in_rd;
                  end else begin
                     out_valid    <= 1'b1;
                     out_result   <= alu_result;
                     out_rd       <= in_rd;
                     out_overflow <= alu_ovf;
                  end
               end
            end
            ST_RUN: begin
               if (mul_done)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               if (!out_valid || out_ready) begin
                  out_valid    <= 1'b1;
                  out_result   <= mul_product;
                  out_rd       <= mul_rd;
                  out_overflow <= 1'b0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`else
   assign in_ready = !rst && (!out_valid || out_ready);
   assign busy     = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd       <= '0;
         out_overflow <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            out_valid    <= 1'b1;
            out_result   <= alu_result;
            out_rd       <= in_rd;
            out_overflow <= alu_ovf;
         end
      end
   end
`endif

endmodule
